// File: rtl/ymux_pkg.sv
// Shared constants and width helpers for the round-robin multiplexer.
// The YMUX_RR_STATS_EN build adds a transfer counter of width CNT_W.
package ymux_pkg;

  localparam int unsigned CNT_W = 16;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = (n > 0) ? n - 1 : 0; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Grant index width: never narrower than one bit, even for a single channel.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ymux_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module ymux_rr_pick import ymux_pkg::*; #(
  parameter int unsigned N = 4,
  localparam int unsigned SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            any
);

  always_comb begin
    grant = '0;
    any   = 1'b0;
    // Upper pass covers ptr..N-1, lower pass wraps to 0..ptr-1.
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= 32'(ptr))) begin
        any   = 1'b1;
        grant = SELW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i] && (i < 32'(ptr))) begin
        any   = 1'b1;
        grant = SELW'(i);
      end
    end
  end

endmodule

// File: rtl/ymux_rr_arb.sv
// N-channel valid/ready multiplexer with round-robin select and one registered output stage.
// Defining YMUX_RR_STATS_EN adds the xfer_count output (transfers out, wrapping).
module ymux_rr_arb import ymux_pkg::*; #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4,
  localparam int unsigned SELW = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*W-1:0]     in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
`ifdef YMUX_RR_STATS_EN
  ,
  output logic [CNT_W-1:0]   xfer_count
`endif
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] grant, ptr_adv;
  logic            any;
  logic            can_load, xfer_in, xfer_out;
  logic [W-1:0]    grant_data;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;

  ymux_rr_pick #(
    .N (N)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any)
  );

  assign can_load = !out_valid_q || out_ready;
  assign xfer_in  = can_load && any && !reset;
  assign xfer_out = out_valid_q && out_ready && !reset;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant == SELW'(k)) begin
        in_ready[k] = xfer_in;
        grant_data  = in_data[k*W +: W];
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_comb begin
    ptr_adv = '0;
    if (N > 1 && grant != SELW'(N - 1)) begin
      ptr_adv = grant + SELW'(1);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant;
      ptr_d       = ptr_adv;
    end else if (xfer_out) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef YMUX_RR_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (xfer_out) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign xfer_count = cnt_q;
`endif

  ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(in_ready));

endmodule

// File: doc/ymux_rr_arb.md
Name: ymux_rr_arb

Overview:
- Parametrised successor to the fixed 2:1 yMux: an N-channel, W-bit multiplexer whose select comes from an internal round-robin arbiter instead of a select input.
- Each input channel uses a valid/ready handshake. One registered output stage, also valid/ready.
- Sits between multiple producers (e.g. fetch/load requesters) and one shared consumer in the lab datapath.

Parameters:
- W, 32, data width per channel (>=1)
- N, 4, number of input channels (>=1)
- SELW, derived = max(1, clog2(N)), width of the grant index

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  N  per-channel request
- in_data  in  N*W  channel k occupies bits [k*W +: W]
- in_ready  out  N  per-channel accept (one-hot or zero)
- out_valid  out  1  output register holds a word
- out_data  out  W  registered data
- out_sel  out  SELW  channel index the word came from
- out_ready  in  1  consumer accepts

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on reset. On reset: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
- can_load = !out_valid | out_ready (combinational).
- Arbitration (combinational): grant = first k with in_valid[k]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- in_ready[grant] = can_load & |in_valid. All other in_ready bits = 0. in_ready is 0 while reset=1.
- Transfer in: in_valid[k] & in_ready[k]. At the next edge: out_data<=in_data[k], out_sel<=k, out_valid<=1, ptr<=(k+1) mod N (wraps N-1 -> 0).
- Transfer out: out_valid & out_ready. If there is no simultaneous transfer in, out_valid<=0 at the next edge.
- Simultaneous in and out in one cycle: the register is replaced. Full throughput is 1 word per cycle.
- Latency: input accepted at edge t appears at the output after edge t (1 cycle).
- Stall: while out_valid & !out_ready, out_data and out_sel hold stable, all in_ready=0, and ptr holds.
- ptr advances only on a transfer in. Idle cycles leave it unchanged.
- N=1: ptr is fixed at 0, out_sel is always 0, and the block degenerates to a 1-deep pipeline register.
- Reset asserted mid-stall drops the held word; there is no flush handshake.
- Channels must hold in_valid/in_data until accepted. The block does not check this.

Optional Feature:
- Macro YMUX_RR_STATS_EN.
- Defined: adds output port xfer_count [15:0]. It resets to 0 and increments on every transfer out, wrapping 0xFFFF -> 0x0000.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package ymux_pkg:
  - constant function for clog2
  - localparam CNT_W=16 for the stats counter
- Sub-module ymux_rr_pick (combinational): inputs req[N] and ptr[SELW]; outputs grant[SELW] and any. Keep it purely combinational so it can be exhaustively tested alone.

Test Plan:
1. Reset with all in_valid=1 -> out_valid=0, in_ready=0 during reset. First cycle after reset: in_ready=4'b0001.
2. W=8, N=4, all channels valid (data 0x10, 0x11, 0x12, 0x13), out_ready=1 -> out_sel sequence 0,1,2,3,0, with out_data matching, one word per cycle.
3. ptr=2, only channel 0 and channel 3 valid -> channel 3 granted first, then 0 (wrap-around).
4. out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_sel stable, in_ready=0. Release -> transfer resumes next cycle, no word lost or duplicated.
5. reset pulsed while stalled with a word held -> out_valid=0 next cycle, ptr=0.
6. YMUX_RR_STATS_EN defined, 0x10002 transfers out -> xfer_count=0x0002. N=1 build: single channel passes data with 1-cycle latency.
